// File: rtl/data_buffer.sv
// Synchronous FIFO staging words between the copier's source-read and destination-write sides.
// First-word fall-through read port, occupancy count, flush and sticky error flags.
module data_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLR,
    input  logic                       WEN,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       REN,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wp, rp;
    logic [CW-1:0]               cnt;
    logic                        rd_ok, wr_ok;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // A full buffer still accepts a write when the same cycle pops a word.
    assign rd_ok = REN && !empty;
    assign wr_ok = WEN && (!full || rd_ok);

    // Head is driven purely from registered state, so no input-to-rdata path exists.
    assign rdata = empty ? '0 : mem[rp];

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (WEN && !wr_ok) overflow  <= 1'b1;
            if (REN && !rd_ok) underflow <= 1'b1;
        end
    end

    // Storage is left unreset; the pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (!RST && !CLR && wr_ok) mem[wp] <= wdata;
    end
endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: vector table on a 8x4 instance, hand sequences for
// wrap streaming and a 32x16 instance for the parameter sweep.
module tb_data_buffer;
    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 8-bit x 4 instance
    logic        a_rst, a_clr, a_wen, a_ren;
    logic [7:0]  a_wdata, a_rdata;
    logic        a_full, a_empty, a_ovf, a_unf;
    logic [2:0]  a_count;

    // 32-bit x 16 instance
    logic        b_rst, b_clr, b_wen, b_ren;
    logic [31:0] b_wdata, b_rdata;
    logic        b_full, b_empty, b_ovf, b_unf;
    logic [4:0]  b_count;

    data_buffer #(.WIDTH(8), .DEPTH(4)) u_a (
        .CLK(CLK), .RST(a_rst), .CLR(a_clr), .WEN(a_wen), .wdata(a_wdata), .REN(a_ren),
        .rdata(a_rdata), .full(a_full), .empty(a_empty), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf));

    data_buffer #(.WIDTH(32), .DEPTH(16)) u_b (
        .CLK(CLK), .RST(b_rst), .CLR(b_clr), .WEN(b_wen), .wdata(b_wdata), .REN(b_ren),
        .rdata(b_rdata), .full(b_full), .empty(b_empty), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf));

    typedef struct {
        logic       rst, clr, wen;
        logic [7:0] wd;
        logic       ren;
        logic [2:0] c;
        logic       e, f;
        logic [7:0] rd;
        logic       o, u;
    } vec_t;

    vec_t vq[$];
    int   npass = 0;
    int   ntotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic rst, clr, wen, input logic [7:0] wd, input logic ren,
                       input logic [2:0] c, input logic e, f, input logic [7:0] rd,
                       input logic o, u);
        vec_t v;
        v.rst = rst; v.clr = clr; v.wen = wen; v.wd = wd; v.ren = ren;
        v.c = c; v.e = e; v.f = f; v.rd = rd; v.o = o; v.u = u;
        vq.push_back(v);
    endtask

    task automatic a_drive(input logic rst, clr, wen, input logic [7:0] wd, input logic ren);
        @(negedge CLK);
        a_rst = rst; a_clr = clr; a_wen = wen; a_wdata = wd; a_ren = ren;
        @(posedge CLK);
        #1;
    endtask

    task automatic b_drive(input logic rst, wen, input logic [31:0] wd, input logic ren);
        @(negedge CLK);
        b_rst = rst; b_clr = 1'b0; b_wen = wen; b_wdata = wd; b_ren = ren;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_wen = 1'b0; a_ren = 1'b0; a_wdata = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_wdata = '0;

        //  rst clr wen wd    ren   cnt e  f  rdata  o  u
        add(1, 0, 0, 8'h00, 0,  0, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0,  0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 8'h11, 0,  1, 0, 0, 8'h11, 0, 0);
        add(0, 0, 1, 8'h22, 0,  2, 0, 0, 8'h11, 0, 0);
        add(0, 0, 1, 8'h33, 0,  3, 0, 0, 8'h11, 0, 0);
        add(0, 0, 1, 8'h44, 0,  4, 0, 1, 8'h11, 0, 0);
        add(0, 0, 1, 8'h55, 0,  4, 0, 1, 8'h11, 1, 0);  // rejected write
        add(0, 0, 0, 8'h00, 1,  3, 0, 0, 8'h22, 1, 0);
        add(0, 0, 0, 8'h00, 1,  2, 0, 0, 8'h33, 1, 0);
        add(0, 0, 0, 8'h00, 1,  1, 0, 0, 8'h44, 1, 0);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 1, 0);
        add(0, 0, 1, 8'hA0, 1,  1, 0, 0, 8'hA0, 1, 1);  // empty: write wins, read rejected
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 1, 1);
        add(0, 0, 1, 8'hB1, 0,  1, 0, 0, 8'hB1, 1, 1);
        add(0, 0, 1, 8'hB2, 0,  2, 0, 0, 8'hB1, 1, 1);
        add(0, 0, 1, 8'hB3, 0,  3, 0, 0, 8'hB1, 1, 1);
        add(0, 0, 1, 8'hB4, 0,  4, 0, 1, 8'hB1, 1, 1);
        add(0, 0, 1, 8'hB0, 1,  4, 0, 1, 8'hB2, 1, 1);  // full: push+pop both accepted
        add(0, 0, 0, 8'h00, 1,  3, 0, 0, 8'hB3, 1, 1);
        add(0, 0, 0, 8'h00, 1,  2, 0, 0, 8'hB4, 1, 1);
        add(0, 0, 0, 8'h00, 1,  1, 0, 0, 8'hB0, 1, 1);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 1, 1);
        add(0, 0, 1, 8'h01, 0,  1, 0, 0, 8'h01, 1, 1);
        add(0, 0, 1, 8'h02, 0,  2, 0, 0, 8'h01, 1, 1);
        add(0, 0, 1, 8'h03, 0,  3, 0, 0, 8'h01, 1, 1);
        add(0, 1, 1, 8'h04, 1,  0, 1, 0, 8'h00, 0, 0);  // CLR beats WEN/REN
        add(0, 0, 1, 8'h05, 0,  1, 0, 0, 8'h05, 0, 0);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 0, 1);
        add(0, 0, 1, 8'h06, 0,  1, 0, 0, 8'h06, 0, 1);
        add(0, 0, 1, 8'h07, 0,  2, 0, 0, 8'h06, 0, 1);
        add(0, 0, 1, 8'h08, 0,  3, 0, 0, 8'h06, 0, 1);
        add(0, 0, 1, 8'h09, 0,  4, 0, 1, 8'h06, 0, 1);
        add(0, 0, 1, 8'h0A, 0,  4, 0, 1, 8'h06, 1, 1);
        add(0, 0, 0, 8'h00, 1,  3, 0, 0, 8'h07, 1, 1);
        add(1, 0, 1, 8'h0B, 1,  0, 1, 0, 8'h00, 0, 0);  // RST behaves like CLR
        add(0, 0, 0, 8'h00, 0,  0, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            a_drive(vq[i].rst, vq[i].clr, vq[i].wen, vq[i].wd, vq[i].ren);
            chk($sformatf("v%0d count", i),     32'(a_count), 32'(vq[i].c));
            chk($sformatf("v%0d empty", i),     32'(a_empty), 32'(vq[i].e));
            chk($sformatf("v%0d full", i),      32'(a_full),  32'(vq[i].f));
            chk($sformatf("v%0d rdata", i),     32'(a_rdata), 32'(vq[i].rd));
            chk($sformatf("v%0d overflow", i),  32'(a_ovf),   32'(vq[i].o));
            chk($sformatf("v%0d underflow", i), 32'(a_unf),   32'(vq[i].u));
        end

        // Wrap streaming on the small instance: one pre-write, then 20 push+pop cycles.
        a_drive(0, 0, 1, 8'h00, 0);
        chk("a_stream pre rdata", 32'(a_rdata), 32'h00);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("a_stream%0d head", i), 32'(a_rdata), 32'(i));
            a_drive(0, 0, 1, 8'(i + 1), 1);
            chk($sformatf("a_stream%0d count", i), 32'(a_count), 32'd1);
        end
        chk("a_stream flags", {30'd0, a_ovf, a_unf}, 32'd0);
        a_drive(0, 0, 0, 8'h00, 0);

        // Parameter sweep: 32-bit x 16 instance.
        b_drive(1, 0, 32'd0, 0);
        chk("b reset count", 32'(b_count), 32'd0);
        chk("b reset empty", 32'(b_empty), 32'd1);
        for (int i = 0; i < 16; i++) begin
            b_drive(0, 1, 32'hC0DE_0000 + 32'(i * 7), 0);
            chk($sformatf("b_fill%0d count", i), 32'(b_count), 32'(i + 1));
            chk($sformatf("b_fill%0d full", i),  32'(b_full),  32'(i == 15));
            chk($sformatf("b_fill%0d head", i),  b_rdata, 32'hC0DE_0000);
        end
        b_drive(0, 1, 32'hDEAD_BEEF, 0);
        chk("b overflow", 32'(b_ovf), 32'd1);
        chk("b ovf count", 32'(b_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b_drain%0d head", i), b_rdata, 32'hC0DE_0000 + 32'(i * 7));
            b_drive(0, 0, 32'd0, 1);
            chk($sformatf("b_drain%0d count", i), 32'(b_count), 32'(15 - i));
        end
        chk("b drained empty", 32'(b_empty), 32'd1);
        chk("b drained rdata", b_rdata, 32'd0);
        b_drive(0, 1, 32'h8000_0000, 0);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("b_stream%0d head", i), b_rdata, 32'h8000_0000 + 32'(i));
            b_drive(0, 1, 32'h8000_0001 + 32'(i), 1);
            chk($sformatf("b_stream%0d count", i), 32'(b_count), 32'd1);
        end
        chk("b stream underflow", 32'(b_unf), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
